// File: rtl/tile_writeback.sv
// tile_writeback: 16x16 tile compositor with ping-pong tile buffer and
// frame-buffer writeback over a valid/ready stream.
// Optional feature macro: TILE_WB_ZTEST_EN enables per-pixel depth resolve
// (a write to an already-written pixel lands only if its z is >= the stored z).
// Without the macro, z is not stored and the last write to a pixel wins.
module tile_writeback #(
    parameter int PIXEL_W   = 8,
    parameter int FB_ADDR_W = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_pix_we,
    input  logic [7:0]           i_pix_addr,
    input  logic [PIXEL_W-1:0]   i_pix_data,
    input  logic [7:0]           i_pix_z,
    input  logic                 i_sm_render_done,
    input  logic [5:0]           i_done_tile_x,
    input  logic [5:0]           i_done_tile_y,
    output logic                 o_fb_valid,
    output logic [FB_ADDR_W-1:0] o_fb_addr,
    output logic [PIXEL_W-1:0]   o_fb_data,
    input  logic                 i_fb_ready,
    output logic                 o_busy,
    output logic                 o_tile_done,
    output logic                 o_overrun,
    input  logic                 i_overrun_clr
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [5:0] MAX_TILE_X = 6'd39;
    localparam logic [5:0] MAX_TILE_Y = 6'd29;

    logic [0:0]         state;
    logic               rb;          // render bank; ~rb is the drain bank
    logic [1:0][255:0]  pix_vld;     // per-bank, per-pixel "written this tile" flags
    logic [PIXEL_W-1:0] color_mem [2][256];
`ifdef TILE_WB_ZTEST_EN
    logic [7:0]         z_mem [2][256];
`else
    logic               unused_pix_z;
`endif
    logic [7:0]         beat_k;
    logic [5:0]         tile_x;
    logic [5:0]         tile_y;

    logic               done_accept;
    logic               tile_in_range;
    logic               pix_lands;
    logic               beat_accept;
    logic               drain_bank;
    logic [FB_ADDR_W-1:0] line_idx;
    logic [FB_ADDR_W-1:0] col_idx;

    // Decode completion acceptance, depth test and beat handshake.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        done_accept   = 1'b0;
        tile_in_range = 1'b0;
        pix_lands     = 1'b1;
        beat_accept   = 1'b0;
        // A completion during the o_tile_done cycle is not taken; the FSM
        // only re-arms one cycle later.
        done_accept   = i_sm_render_done && (state == ST_IDLE) && !o_tile_done;
        tile_in_range = (i_done_tile_x <= MAX_TILE_X) && (i_done_tile_y <= MAX_TILE_Y);
`ifdef TILE_WB_ZTEST_EN
        pix_lands     = !pix_vld[rb][i_pix_addr] || (i_pix_z >= z_mem[rb][i_pix_addr]);
`endif
        beat_accept   = o_fb_valid && i_fb_ready;
    end

`ifndef TILE_WB_ZTEST_EN
    assign unused_pix_z = ^i_pix_z;
`endif

    // Control state: FSM, bank select, valid bits, beat counter, status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rb          <= 1'b0;
            pix_vld     <= '0;
            beat_k      <= '0;
            tile_x      <= '0;
            tile_y      <= '0;
            o_tile_done <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            o_tile_done <= 1'b0;

            // Shader writes always target the pre-swap render bank.
            if (i_pix_we && pix_lands) begin
                pix_vld[rb][i_pix_addr] <= 1'b1;
            end

            if (done_accept) begin
                rb           <= ~rb;
                pix_vld[~rb] <= '0;
                if (tile_in_range) begin
                    state  <= ST_DRAIN;
                    beat_k <= '0;
                    tile_x <= i_done_tile_x;
                    tile_y <= i_done_tile_y;
                end else begin
                    o_tile_done <= 1'b1;
                end
            end

            if ((state == ST_DRAIN) && beat_accept) begin
                beat_k <= beat_k + 8'd1;
                if (beat_k == 8'd255) begin
                    state       <= ST_IDLE;
                    o_tile_done <= 1'b1;
                end
            end

            // A new overrun takes priority over a simultaneous clear.
            if (i_sm_render_done && !done_accept) begin
                o_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                o_overrun <= 1'b0;
            end
        end
    end

    // Tile pixel storage; validity is tracked separately in pix_vld.
    always_ff @(posedge clk) begin
        // NOTE: the storage arrays are deliberately not reset; the valid bits
        // gate every read, so stale contents are never observed.
        if (i_pix_we && pix_lands) begin
            color_mem[rb][i_pix_addr] <= i_pix_data;
`ifdef TILE_WB_ZTEST_EN
            z_mem[rb][i_pix_addr]     <= i_pix_z;
`endif
        end
    end

    // Drain beat: linear frame-buffer address and colour from the drain bank.
    assign drain_bank = ~rb;
    assign o_busy     = (state == ST_DRAIN);
    assign o_fb_valid = (state == ST_DRAIN);
    assign line_idx   = FB_ADDR_W'({tile_y, beat_k[7:4]});
    assign col_idx    = FB_ADDR_W'({tile_x, beat_k[3:0]});
    assign o_fb_addr  = o_fb_valid ? (line_idx * FB_ADDR_W'(640) + col_idx) : '0;
    assign o_fb_data  = (o_fb_valid && pix_vld[drain_bank][beat_k])
                        ? color_mem[drain_bank][beat_k] : '0;

endmodule

// File: doc/tile_writeback.md
# tile_writeback

Tile compositor and frame-buffer writeback stage, directly downstream of the GPU tile controller and the shader unit. It collects the pixels of the 16x16 tile being rendered into a ping-pong tile buffer with per-pixel depth resolve. When the controller signals tile completion it swaps banks and streams the finished tile to frame-buffer memory over a valid/ready interface.

## Interface
Parameters:
- PIXEL_W, 8: colour bits per pixel.
- FB_ADDR_W, 19: frame-buffer word address width; must cover 640*480 = 307200 pixels.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_pix_we  in  1  shader pixel write strobe.
- i_pix_addr  in  8  pixel index in tile, row*16 + col.
- i_pix_data  in  PIXEL_W  pixel colour.
- i_pix_z  in  8  pixel depth; 0 = background.
- i_sm_render_done  in  1  one-cycle pulse; the render tile is complete.
- i_done_tile_x  in  6  tile column of the completed tile, 0..39; sampled with i_sm_render_done.
- i_done_tile_y  in  6  tile row of the completed tile, 0..29; sampled with i_sm_render_done.
- o_fb_valid  out  1  frame-buffer write beat valid.
- o_fb_addr  out  FB_ADDR_W  linear pixel address.
- o_fb_data  out  PIXEL_W  pixel colour.
- i_fb_ready  in  1  frame buffer accepts the beat.
- o_busy  out  1  drain in progress.
- o_tile_done  out  1  one-cycle pulse; drain finished or tile skipped.
- o_overrun  out  1  sticky; a completion arrived while busy.
- i_overrun_clr  in  1  clears o_overrun.

## Operation
- Two banks, each 256 x (PIXEL_W colour + 8 z + 1 valid bit). Bank select bit rb marks the render bank; !rb is the drain bank.
- Pixel write (i_pix_we):
  - Target is bank rb, entry i_pix_addr.
  - If the entry's valid bit is 0, the write always lands and sets the valid bit.
  - Otherwise the write lands only if the depth test passes (see Configuration).
- Completion, i_sm_render_done while IDLE:
  - Toggle rb.
  - Clear all 256 valid bits of the new render bank in the same edge.
  - Latch the tile coordinates and enter DRAIN.
- Completion with out-of-range coordinates (x > 39 or y > 29):
  - The bank still swaps; DRAIN is skipped.
  - o_tile_done pulses on the next cycle.
- Completion while in DRAIN:
  - No swap; o_overrun is set.
  - Subsequent shader writes keep merging into the current render bank.
  - i_overrun_clr and a new overrun in the same cycle: set wins.
- A pixel write in the same cycle as an accepted completion lands in the closing bank (pre-swap rb).
- FSM states:
  - IDLE to DRAIN on an accepted in-range completion.
  - DRAIN to IDLE on acceptance of beat 255.
- DRAIN:
  - Beat index k counts 0..255, with row = k[7:4] and col = k[3:0].
  - o_fb_addr = (tile_y*16 + row)*640 + tile_x*16 + col, computed at FB_ADDR_W bits with no truncation (maximum 307199).
  - o_fb_data = stored colour if valid, else 0.
  - k advances only on o_fb_valid & i_fb_ready.
- Reset mid-drain: the drain is abandoned, both banks' valid bits are cleared, and rb = 0.

## Timing
- Reset values: o_fb_valid 0, o_fb_addr 0, o_fb_data 0, o_busy 0, o_tile_done 0, o_overrun 0, rb 0, all valid bits 0, FSM IDLE.
- Completion at edge N produces beat 0 with o_fb_valid = 1 and o_busy = 1 in cycle N+1.
- With i_fb_ready held high, beats run one per cycle.
- The final acceptance occurs at edge N+256. o_busy and o_fb_valid are 0 and o_tile_done = 1 in cycle N+257.
- A new completion is accepted in the cycle after o_tile_done, not during it.
- While o_fb_valid = 1 and i_fb_ready = 0, o_fb_addr and o_fb_data hold stable.
- o_fb_valid never drops before acceptance.
- Pixel writes take effect at the next edge. Reads of the drain bank are combinational from the stored arrays, and drain bank contents are never modified by shader writes.

## Configuration
- TILE_WB_ZTEST_EN defined:
  - A write to a valid entry lands iff i_pix_z >= stored z.
  - An equal z lands, so the later write wins.
- Not defined:
  - z storage is omitted.
  - Every write lands (last write wins) and i_pix_z is ignored.

## Test plan
- Write pixel 0x11 at all 256 addresses with z=0, complete tile (5,3) with ready high: 256 beats. First beat has addr 30800 (3*16*640 + 80), last beat addr 40415, all data 0x11. o_tile_done pulses at cycle N+257.
- ZTEST_EN: to addr 0, write (data 0xAA, z 4), then (0xBB, z 2), then (0xCC, z 4): beat 0 data = 0xCC. Without the macro, the same writes give 0xCC, and a final (0xDD, z 1) gives 0xDD.
- Complete a tile with only addr 17 written (0x5A): beat 17 = 0x5A and all other beats 0. On the next tile, no stale data appears.
- Drop i_fb_ready for 3 cycles at beat 100: addr/data hold for 3 cycles, 256 beats total, no duplicate or skipped beats.
- Pulse i_sm_render_done at beat 50 of a drain: o_overrun = 1 and the current drain is unaffected. i_overrun_clr clears it. A completion for tile (40,0) causes no beats, only an o_tile_done pulse one cycle later.
- Assert reset at beat 128: all outputs return to reset values asynchronously, and a fresh tile afterwards drains with only new data.
